// File: rtl/sort_output_serializer.sv
// rtl/sort_output_serializer.sv - two-slot buffer that serializes sorted vectors into element beats
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-low reset
//   x_valid    sorted vector present (1-cycle pulse, no backpressure upstream)
//   x          N packed data elements, element i at x[DATA_WIDTH*i +: DATA_WIDTH]
//   x_label    N packed labels, element i at x_label[LABEL_WIDTH*i +: LABEL_WIDTH]
//   y_ready    downstream accepts beat
//   y_valid    beat valid
//   y          current element data
//   y_label    current element label
//   y_index    element position within its vector
//   y_last     final beat of the current vector
//   occupancy  vectors buffered (0..2), including the one being emitted
//   drop       1-cycle pulse: incoming vector discarded because buffer was full
//   overflow   sticky: any drop since reset
module sort_output_serializer #(
  parameter int DATA_WIDTH  = 8,
  parameter int LABEL_WIDTH = 1,
  parameter int N           = 16,
  parameter int REVERSE     = 0,
  localparam int IDX_W      = $clog2(N)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     x_valid,
  input  logic [DATA_WIDTH*N-1:0]  x,
  input  logic [LABEL_WIDTH*N-1:0] x_label,
  input  logic                     y_ready,
  output logic                     y_valid,
  output logic [DATA_WIDTH-1:0]    y,
  output logic [LABEL_WIDTH-1:0]   y_label,
  output logic [IDX_W-1:0]         y_index,
  output logic                     y_last,
  output logic [1:0]               occupancy,
  output logic                     drop,
  output logic                     overflow
);

  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(N - 1);

  logic [DATA_WIDTH*N-1:0]  slot_data  [2];
  logic [LABEL_WIDTH*N-1:0] slot_label [2];
  logic                     wr_ptr;
  logic                     rd_ptr;
  logic [IDX_W-1:0]         beat;
  logic [IDX_W-1:0]         elem;
  logic                     beat_fire;
  logic                     freeing;
  logic                     capture;

  assign y_valid   = (occupancy != 2'd0);
  assign beat_fire = y_valid && y_ready;
  // The slot being emitted is released on its last handshake, so a vector
  // arriving in that same cycle may reuse it even though the buffer looks full.
  assign freeing   = beat_fire && (beat == LAST_BEAT);
  assign capture   = x_valid && ((occupancy != 2'd2) || freeing);
  assign elem      = (REVERSE != 0) ? (LAST_BEAT - beat) : beat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      beat      <= '0;
      occupancy <= 2'd0;
      drop      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (capture) begin
        wr_ptr <= ~wr_ptr;
      end
      if (beat_fire) begin
        beat <= freeing ? '0 : beat + IDX_W'(1);
      end
      if (freeing) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({capture, freeing})
        2'b10:   occupancy <= occupancy + 2'd1;
        2'b01:   occupancy <= occupancy - 2'd1;
        default: occupancy <= occupancy;
      endcase
      drop <= x_valid && !capture;
      if (x_valid && !capture) begin
        overflow <= 1'b1;
      end
    end
  end

  // Payload storage needs no reset: nothing is read until occupancy says a
  // slot holds a captured vector.
  always_ff @(posedge clk) begin
    if (capture) begin
      slot_data[wr_ptr]  <= x;
      slot_label[wr_ptr] <= x_label;
    end
  end

  // Outputs are forced to zero while idle so reset clears them immediately.
  always_comb begin
    y       = '0;
    y_label = '0;
    y_index = '0;
    y_last  = 1'b0;
    if (y_valid) begin
      y       = slot_data[rd_ptr][DATA_WIDTH*int'(elem) +: DATA_WIDTH];
      y_label = slot_label[rd_ptr][LABEL_WIDTH*int'(elem) +: LABEL_WIDTH];
      y_index = elem;
      y_last  = (beat == LAST_BEAT);
    end
  end

endmodule

// File: tb/tb_sort_output_serializer.sv
// tb/tb_sort_output_serializer.sv - bench for sort_output_serializer, forward and reversed instances
module tb_sort_output_serializer;

  localparam int DW = 8;
  localparam int LW = 1;
  localparam int N  = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          x_valid = 1'b0;
  logic          y_ready = 1'b0;
  logic [DW*N-1:0] x = '0;
  logic [LW*N-1:0] x_label = '0;

  logic          yv_f, yl_f, dr_f, ov_f;
  logic [DW-1:0] y_f;
  logic [LW-1:0] lab_f;
  logic [IW-1:0] idx_f;
  logic [1:0]    occ_f;

  logic          yv_r, yl_r, dr_r, ov_r;
  logic [DW-1:0] y_r;
  logic [LW-1:0] lab_r;
  logic [IW-1:0] idx_r;
  logic [1:0]    occ_r;

  sort_output_serializer #(.DATA_WIDTH(DW), .LABEL_WIDTH(LW), .N(N), .REVERSE(0)) dut (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .x_label(x_label), .y_ready(y_ready),
    .y_valid(yv_f), .y(y_f), .y_label(lab_f), .y_index(idx_f), .y_last(yl_f),
    .occupancy(occ_f), .drop(dr_f), .overflow(ov_f)
  );

  sort_output_serializer #(.DATA_WIDTH(DW), .LABEL_WIDTH(LW), .N(N), .REVERSE(1)) dut_r (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .x_label(x_label), .y_ready(y_ready),
    .y_valid(yv_r), .y(y_r), .y_label(lab_r), .y_index(idx_r), .y_last(yl_r),
    .occupancy(occ_r), .drop(dr_r), .overflow(ov_r)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of accepted vectors, the number of beats already
  // delivered from the head vector, and the expected drop/overflow flags.
  logic [DW*N-1:0] qd[$];
  logic [LW*N-1:0] ql[$];
  int  done_beats = 0;
  bit  m_drop = 1'b0;
  bit  m_ovf  = 1'b0;
  int  npass  = 0;
  int  ntotal = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_outs();
    logic [DW*N-1:0] vd;
    logic [LW*N-1:0] vl;
    int ef, er;
    chk("occupancy", 32'(occ_f), qd.size());
    chk("occupancy_rev", 32'(occ_r), qd.size());
    chk("y_valid", 32'(yv_f), 32'(qd.size() != 0));
    chk("y_valid_rev", 32'(yv_r), 32'(qd.size() != 0));
    chk("drop", 32'(dr_f), 32'(m_drop));
    chk("overflow", 32'(ov_f), 32'(m_ovf));
    chk("overflow_rev", 32'(ov_r), 32'(m_ovf));
    if (qd.size() != 0) begin
      vd = qd[0];
      vl = ql[0];
      ef = done_beats;
      er = N - 1 - done_beats;
      chk("y", 32'(y_f), 32'(vd[DW*ef +: DW]));
      chk("y_label", 32'(lab_f), 32'(vl[LW*ef +: LW]));
      chk("y_index", 32'(idx_f), ef);
      chk("y_last", 32'(yl_f), 32'(done_beats == N - 1));
      chk("y_rev", 32'(y_r), 32'(vd[DW*er +: DW]));
      chk("y_label_rev", 32'(lab_r), 32'(vl[LW*er +: LW]));
      chk("y_index_rev", 32'(idx_r), er);
      chk("y_last_rev", 32'(yl_r), 32'(done_beats == N - 1));
    end
  endtask

  // One clock: check at the falling edge, then advance the model by the
  // handshake and capture rules and let the DUT take the rising edge.
  task automatic cycle();
    bit fire, release_slot, take;
    @(negedge clk);
    check_outs();
    fire         = (qd.size() != 0) && y_ready;
    release_slot = fire && (done_beats == N - 1);
    take         = x_valid && ((qd.size() < 2) || release_slot);
    if (fire) done_beats++;
    if (release_slot) begin
      void'(qd.pop_front());
      void'(ql.pop_front());
      done_beats = 0;
    end
    if (take) begin
      qd.push_back(x);
      ql.push_back(x_label);
    end
    m_drop = x_valid && !take;
    if (m_drop) m_ovf = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW*N-1:0] d, input logic [LW*N-1:0] l);
    x       = d;
    x_label = l;
    x_valid = 1'b1;
    cycle();
    x_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_y_valid", {yv_f, yv_r}, 0);
    chk("rst_y", {y_f, y_r}, 0);
    chk("rst_y_label", {lab_f, lab_r}, 0);
    chk("rst_y_index", {idx_f, idx_r}, 0);
    chk("rst_y_last", {yl_f, yl_r}, 0);
    chk("rst_occupancy", {occ_f, occ_r}, 0);
    chk("rst_flags", {dr_f, dr_r, ov_f, ov_r}, 0);
    qd.delete();
    ql.delete();
    done_beats = 0;
    m_drop = 1'b0;
    m_ovf  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic logic [DW*N-1:0] ramp(input int base, input int step);
    logic [DW*N-1:0] v;
    for (int i = 0; i < N; i++) v[DW*i +: DW] = DW'(base + step * i);
    return v;
  endfunction

  function automatic logic [LW*N-1:0] parity_labels();
    logic [LW*N-1:0] l;
    for (int i = 0; i < N; i++) l[LW*i +: LW] = LW'(i % 2);
    return l;
  endfunction

  function automatic logic [DW*N-1:0] rand_vec();
    logic [DW*N-1:0] v;
    for (int i = 0; i < N; i++) v[DW*i +: DW] = DW'($urandom);
    return v;
  endfunction

  initial begin
    #1;
    do_reset();
    repeat (2) cycle();

    // Single vector, always ready: 3*i data, alternating labels.
    y_ready = 1'b1;
    send(ramp(0, 3), parity_labels());
    repeat (20) cycle();

    // Same vector with ready toggling every cycle.
    send(ramp(0, 3), parity_labels());
    for (int i = 0; i < 40; i++) begin
      y_ready = (i % 2 == 0);
      cycle();
    end

    // Fill both slots while stalled, then release; C lands on A's last handshake.
    y_ready = 1'b0;
    send(ramp(0, 1), '0);
    repeat (2) cycle();
    send(ramp(100, 1), '1);
    repeat (2) cycle();
    y_ready = 1'b1;
    repeat (N - 1) cycle();
    send(ramp(200, 1), 16'h5a5a);
    repeat (40) cycle();

    // Third vector into a full buffer is dropped; A and B survive.
    y_ready = 1'b0;
    send(ramp(0, 1), '0);
    cycle();
    send(ramp(100, 1), '1);
    cycle();
    send(ramp(50, 2), '0);
    repeat (3) cycle();
    y_ready = 1'b1;
    repeat (40) cycle();

    // Randomized traffic: sporadic vectors, random backpressure.
    for (int i = 0; i < 600; i++) begin
      y_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) send(rand_vec(), LW*N'($urandom));
      else cycle();
    end

    // Reset in the middle of a vector, then restart from beat 0.
    do_reset();
    y_ready = 1'b1;
    send(ramp(0, 1), parity_labels());
    repeat (5) cycle();
    do_reset();
    cycle();
    send(rand_vec(), parity_labels());
    repeat (20) cycle();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
